addr_decoder: RTL

ADDR_DECODER -- requirements
Module: addr_decoder

---
 rtl/addr_decoder_if.sv | 29 ++
 rtl/addr_decoder.sv | 94 +++++++++
 2 files changed

// File: rtl/addr_decoder_if.sv
// Upstream word bus and downstream four-FIFO write bus of the address decoder.
interface addr_decoder_if #(
  parameter int unsigned W_WIDTH = 32
);
  logic               valid_in;
  logic [W_WIDTH-1:0] data_in;
  logic               ready_out;
  logic [3:0]         fifo_full;
  logic [3:0]         fifo_wr_en;
  logic [W_WIDTH-1:0] fifo_data;

  modport slave (
    input  valid_in,
    input  data_in,
    input  fifo_full,
    output ready_out,
    output fifo_wr_en,
    output fifo_data
  );

  modport master (
    output valid_in,
    output data_in,
    output fifo_full,
    input  ready_out,
    input  fifo_wr_en,
    input  fifo_data
  );
endinterface

// File: rtl/addr_decoder.sv
// Decodes a word's address field against four programmable port addresses
// (plus broadcast) and writes it atomically to every matching downstream FIFO.
module addr_decoder #(
  parameter int unsigned           W_WIDTH    = 32,
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BCAST_ADDR = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  addr_decoder_if.slave         bus,
  input  logic                  cfg_wr_en,
  input  logic [1:0]            cfg_sel,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  output logic [7:0]            drop_cnt
);
  localparam int unsigned     NPORTS  = 4;
  localparam int unsigned     CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ADDR_WIDTH-1:0] port_addr_q [NPORTS];
  logic                  pend_vld_q,  pend_vld_d;
  logic [W_WIDTH-1:0]    pend_data_q, pend_data_d;
  logic [NPORTS-1:0]     pend_mask_q, pend_mask_d;
  logic [CNT_W-1:0]      drop_cnt_q,  drop_cnt_d;

  logic [ADDR_WIDTH-1:0] addr_field_c;
  logic [NPORTS-1:0]     mask_c;
  logic                  issue_c;
  logic                  accept_c;

  assign addr_field_c = bus.data_in[W_WIDTH-1 -: ADDR_WIDTH];

  // Decode against the registers as they stand before any coincident cfg write.
  always_comb begin
    mask_c = '0;
    for (int i = 0; i < NPORTS; i++) begin
      mask_c[i] = (addr_field_c == port_addr_q[i]) || (addr_field_c == BCAST_ADDR);
    end
  end

  // All-or-nothing issue: a multicast word waits until every target has room.
  assign issue_c       = pend_vld_q && ((pend_mask_q & bus.fifo_full) == '0);
  assign bus.ready_out = !pend_vld_q || issue_c;
  assign accept_c      = bus.valid_in && bus.ready_out;

  assign bus.fifo_wr_en = issue_c ? pend_mask_q : '0;
  assign bus.fifo_data  = pend_data_q;
  assign drop_cnt       = drop_cnt_q;

  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
    pend_mask_d = pend_mask_q;
    drop_cnt_d  = drop_cnt_q;
    if (issue_c) begin
      pend_vld_d  = 1'b0;
      pend_mask_d = '0;
    end
    if (accept_c) begin
      if (mask_c != '0) begin
        pend_vld_d  = 1'b1;
        pend_data_d = bus.data_in;
        pend_mask_d = mask_c;
      end else if (drop_cnt_q != CNT_MAX) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q  <= 1'b0;
      pend_data_q <= '0;
      pend_mask_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      pend_vld_q  <= pend_vld_d;
      pend_data_q <= pend_data_d;
      pend_mask_q <= pend_mask_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Port address table; each port defaults to its own index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPORTS; i++) begin
        port_addr_q[i] <= ADDR_WIDTH'(i);
      end
    end else if (cfg_wr_en) begin
      port_addr_q[cfg_sel] <= cfg_addr;
    end
  end
endmodule
